// File: rtl/comp_conv_arb_if.sv
// ============================================================================
// Module  : comp_conv_arb_if
// Brief   : Requester-side and result-side handshake bundle for comp_conv_arb
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface comp_conv_arb_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [7:0]     out_data;
  logic [IDW-1:0] out_id;
  logic           out_ready;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
endinterface

`default_nettype wire

// File: rtl/comp_conv_arb.sv
// ============================================================================
// Module  : comp_conv_arb
// Brief   : Round-robin sharing of one external combinational sign-magnitude
//           to two's-complement converter, with a single registered output.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module comp_conv_arb #(
  parameter int N   = 4,
  parameter int IDW = 2,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  comp_conv_arb_if.slave bus,
  output logic [7:0]    conv_a,
  input  logic [7:0]    conv_y,
  output logic [CW-1:0] conv_cnt
);

  localparam logic [IDW:0] c_n_ext = (IDW+1)'(N);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [7:0]      r_out_data;
  logic [IDW-1:0]  r_out_id;
  logic [CW-1:0]   r_conv_cnt;

  logic [N-1:0]    w_grant;
  logic [IDW-1:0]  w_gidx;
  logic            w_found;
  logic [IDW:0]    w_idx_ext;
  logic [IDW:0]    w_ptr_inc;
  logic [IDW+2:0]  w_sel_lsb;
  logic            w_space;
  logic            w_accept;
  logic            w_handshake;

  // Rotating priority search starting at r_ptr, wrapping at N.
  always_comb begin
    w_grant   = '0;
    w_gidx    = '0;
    w_found   = 1'b0;
    w_idx_ext = '0;
    for (int i = 0; i < N; i++) begin
      w_idx_ext = {1'b0, r_ptr} + (IDW+1)'(i);
      if (w_idx_ext >= c_n_ext) begin
        w_idx_ext = w_idx_ext - c_n_ext;
      end
      if (!w_found && bus.req_valid[w_idx_ext[IDW-1:0]]) begin
        w_found                        = 1'b1;
        w_gidx                         = w_idx_ext[IDW-1:0];
        w_grant[w_idx_ext[IDW-1:0]]    = 1'b1;
      end
    end
  end

  assign w_space     = (r_state == S_EMPTY) || bus.out_ready;
  assign w_accept    = w_space && w_found;
  assign w_handshake = (r_state == S_FULL) && bus.out_ready;

  assign w_sel_lsb     = {w_gidx, 3'b000};
  assign conv_a        = w_found ? bus.req_data[w_sel_lsb +: 8] : 8'h00;
  assign bus.req_ready = w_accept ? w_grant : '0;

  always_comb begin
    w_ptr_inc = {1'b0, w_gidx} + (IDW+1)'(1);
    w_ptr_nxt = (w_ptr_inc == c_n_ext) ? '0 : w_ptr_inc[IDW-1:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
      S_FULL:  if (bus.out_ready && !w_accept) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= 8'h00;
      r_out_id   <= '0;
      r_ptr      <= '0;
      r_conv_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_out_data <= conv_y;
        r_out_id   <= w_gidx;
        r_ptr      <= w_ptr_nxt;
      end
      if (w_handshake) begin
        r_conv_cnt <= r_conv_cnt + CW'(1);
      end
    end
  end

  assign bus.out_valid = (r_state == S_FULL);
  assign bus.out_data  = r_out_data;
  assign bus.out_id    = r_out_id;
  assign conv_cnt      = r_conv_cnt;

endmodule

`default_nettype wire

// File: tb/tb_comp_conv_arb.sv
// ============================================================================
// Module  : tb_comp_conv_arb
// Brief   : Scoreboard bench for comp_conv_arb with a behavioural converter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_comp_conv_arb;

  logic        clk;
  logic        rst_n;
  logic [7:0]  conv_a;
  logic [7:0]  conv_y;
  logic [15:0] conv_cnt;

  int checks = 0;
  int errors = 0;
  int n_push = 0;
  logic [9:0] sb_q[$];

  comp_conv_arb_if #(.N(4), .IDW(2)) bus ();

  comp_conv_arb #(.N(4), .IDW(2), .CW(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .conv_a   (conv_a),
    .conv_y   (conv_y),
    .conv_cnt (conv_cnt)
  );

  // External converter: bit 7 selects negation of the 7-bit magnitude.
  always_comb begin
    conv_y = conv_a;
    if (conv_a[7] && conv_a[6:0] != 7'd0) begin
      conv_y = ~{1'b0, conv_a[6:0]} + 8'd1;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: check req_ready mid-cycle, queue the expected result if accepted.
  task automatic step(input logic [3:0] exp_rdy, input logic [1:0] exp_id, input logic [7:0] exp_dat);
    @(negedge clk);
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    if (exp_rdy != 4'b0000) begin
      sb_q.push_back({exp_id, exp_dat});
      n_push++;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out got id %0d data %0h expected none", bus.out_id, bus.out_data);
      end else begin
        e = sb_q.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(e[7:0]));
        chk("out_id", 32'(bus.out_id), 32'(e[9:8]));
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 4'b0000;
    bus.req_data  = 32'h0;
    bus.out_ready = 1'b0;

    // Reset state
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_id", 32'(bus.out_id), 32'd0);
    chk("rst_conv_cnt", 32'(conv_cnt), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Requester 0 alone
    bus.out_ready = 1'b1;
    step(4'b0000, 2'd0, 8'h00);
    bus.req_valid = 4'b0001;
    bus.req_data[7:0] = 8'h85;
    step(4'b0001, 2'd0, 8'hFB);
    bus.req_valid = 4'b0000;
    step(4'b0000, 2'd0, 8'h00);
    chk("cnt_after_first", 32'(conv_cnt), 32'd1);
    chk("empty_after_first", 32'(bus.out_valid), 32'd0);

    // Requester 2 alone, back-to-back
    bus.req_valid = 4'b0100;
    bus.req_data[23:16] = 8'h05;
    step(4'b0100, 2'd2, 8'h05);
    bus.req_data[23:16] = 8'hFF;
    step(4'b0100, 2'd2, 8'h81);
    bus.req_data[23:16] = 8'h80;
    step(4'b0100, 2'd2, 8'h80);
    bus.req_valid = 4'b0000;
    step(4'b0000, 2'd0, 8'h00);

    // Requester 3 alone moves the pointer back to 0
    bus.req_valid = 4'b1000;
    bus.req_data[31:24] = 8'h8A;
    step(4'b1000, 2'd3, 8'hF6);

    // All requesters valid: strict rotation
    bus.req_valid = 4'b1111;
    bus.req_data  = {8'h90, 8'h7F, 8'h82, 8'h01};
    step(4'b0001, 2'd0, 8'h01);
    step(4'b0010, 2'd1, 8'hFE);
    step(4'b0100, 2'd2, 8'h7F);
    step(4'b1000, 2'd3, 8'hF0);
    step(4'b0001, 2'd0, 8'h01);
    step(4'b0010, 2'd1, 8'hFE);

    // Stall: output held, nothing accepted
    bus.out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_out_data", 32'(bus.out_data), 32'hFE);
      chk("stall_out_id", 32'(bus.out_id), 32'd1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    step(4'b0100, 2'd2, 8'h7F);
    bus.req_valid = 4'b0000;
    step(4'b0000, 2'd0, 8'h00);
    step(4'b0000, 2'd0, 8'h00);
    chk("cnt_before_bulk", 32'(conv_cnt), 32'(n_push));

    // Bulk handshakes up to 16'hFFFE, then wrap
    bus.req_valid = 4'b0001;
    for (int k = n_push; k < 32'hFFFE; k++) begin
      if (k[0]) begin
        bus.req_data[7:0] = 8'h81;
        step(4'b0001, 2'd0, 8'hFF);
      end else begin
        bus.req_data[7:0] = 8'h03;
        step(4'b0001, 2'd0, 8'h03);
      end
    end
    bus.req_valid = 4'b0000;
    step(4'b0000, 2'd0, 8'h00);
    chk("cnt_fffe", 32'(conv_cnt), 32'hFFFE);
    bus.req_valid = 4'b0001;
    bus.req_data[7:0] = 8'h01;
    step(4'b0001, 2'd0, 8'h01);
    bus.req_valid = 4'b0000;
    step(4'b0000, 2'd0, 8'h00);
    chk("cnt_ffff", 32'(conv_cnt), 32'hFFFF);
    bus.req_valid = 4'b0001;
    step(4'b0001, 2'd0, 8'h01);
    bus.req_valid = 4'b0000;
    step(4'b0000, 2'd0, 8'h00);
    chk("cnt_wrap", 32'(conv_cnt), 32'h0000);

    // Reset while FULL, between clock edges; result is discarded
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0010;
    bus.req_data[15:8] = 8'h11;
    @(negedge clk);
    chk("pre_rst_req_ready", 32'(bus.req_ready), 32'b0010);
    @(posedge clk); #1;
    bus.req_valid = 4'b0000;
    chk("pre_rst_full", 32'(bus.out_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_out_data", 32'(bus.out_data), 32'd0);
    chk("async_conv_cnt", 32'(conv_cnt), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Pointer back at 0: requester 0 wins over 3
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b1001;
    bus.req_data[7:0]   = 8'h83;
    bus.req_data[31:24] = 8'h44;
    step(4'b0001, 2'd0, 8'hFD);
    bus.req_valid = 4'b1000;
    step(4'b1000, 2'd3, 8'h44);
    bus.req_valid = 4'b0000;
    step(4'b0000, 2'd0, 8'h00);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
